aes_job_arbiter: RTL and testbench
==================================

Name: aes_job_arbiter

Overview:
- Shares one AES-256 encrypt core among NREQ requesters.
- Arbitrates round-robin, captures the winning block and key, and pulses the core start.
- Waits for core completion under a watchdog, then returns the ciphertext tagged with the requester ID.
- Sits between the host-side request ports and the single encrypt datapath instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 128, maximum cycles spent in BUSY before the job is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_data  in  NREQ*128  plaintext, requester i at bits [128i+127:128i]
- req_key  in  NREQ*256  key, requester i at bits [256i+255:256i]
- core_start  out  1  one-cycle start pulse to the core
- core_data  out  128  plaintext to the core, registered
- core_key  out  256  key to the core, registered
- core_done  in  1  core result-valid pulse
- core_result  in  128  core ciphertext, valid with core_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer accept
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  128  ciphertext, or 0 on error
- rsp_err  out  1  job timed out
- busy  out  1  high in any state except IDLE
- job_count  out  16  completed responses, wraps modulo 2^16

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; timeout counter 0; job_count 0.
- Reset mid-job abandons the job; no response is produced.
- State machine: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
- IDLE, arbitration:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot on the grant, combinational from req_valid and rr_ptr; all zero outside IDLE.
  - A handshake is req_valid[g] && req_ready[g]. On handshake: latch req_data/req_key slices into core_data/core_key, latch g as rsp_id, set rr_ptr = (g+1) mod NREQ, go to ISSUE.
  - No valid requester: stay in IDLE; rr_ptr unchanged.
- ISSUE: core_start = 1 for exactly this cycle; clear the timeout counter; go to BUSY.
- core_data and core_key hold stable from ISSUE until the next handshake.
- BUSY:
  - Counter increments each cycle.
  - On core_done: capture core_result into rsp_data, rsp_err = 0, go to RESP.
  - Otherwise, when counter == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - core_done in the same cycle as timeout: done wins, no error.
- core_done outside BUSY is ignored, including a late done after a timeout.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err stay stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready: rsp_valid falls next cycle, job_count increments (errors included), go to IDLE.
  - No new grant in the same cycle; minimum one IDLE cycle between jobs.
- Latency: handshake at cycle T; core_start at T+1; BUSY from T+2; rsp_valid one cycle after the core_done cycle.
- req_valid deasserted before being granted: the job is dropped, no state change. Requesters must not drop req_valid once asserted.
- job_count wrap: 0xFFFF -> 0x0000.

Test Plan:
- Single job: req 2 valid, data 0x00112233445566778899aabbccddeeff, key 0x000102…1f; core model with 57-cycle latency returning 0x8ea2b7ca516745bfeafc49904b496089. Expect req_ready[2] at T, core_start at T+1 only, rsp_valid with rsp_id=2, that ciphertext, rsp_err=0, job_count=1.
- Round-robin: all 4 requesters held valid. Grants follow 0,1,2,3,0. Then with only reqs 1 and 3 valid and rr_ptr=2, expect grant 3, then 1.
- Backpressure: rsp_ready low for 10 cycles in RESP. rsp_* stays stable; req_ready stays 0; no core_start; job_count increments only on the accept cycle.
- Timeout: TIMEOUT=16, core never returns done. rsp_valid with rsp_err=1 and rsp_data=0, 16 cycles after BUSY entry. A late core_done afterwards must have no effect.
- Done on the final BUSY cycle (counter = TIMEOUT-1): expect rsp_err=0 and rsp_data = core_result.
- Async reset pulsed mid-BUSY: all outputs 0 immediately; rr_ptr 0; the next job with reqs 0 and 1 valid grants 0.

Source files
------------

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES-256 encrypt core among NREQ requesters.
// Captures block and key, starts the core, and returns the tagged result or a timeout error.
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot on the round-robin winner
// ISSUE | one-cycle core_start pulse, watchdog cleared
// BUSY  | waiting for core_done under the watchdog
// RESP  | holding the response until rsp_ready
module aes_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128-1:0]   req_data,
    input  logic [NREQ*256-1:0]   req_key,
    output logic                  core_start,
    output logic [127:0]          core_data,
    output logic [255:0]          core_key,
    input  logic                  core_done,
    input  logic [127:0]          core_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [127:0]          rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           job_count
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           take;

    // Walk the ring from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == ((int'(rr_ptr) + k) % NREQ) && req_valid[i]) begin
                    grant     = IDW'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
    assign take    = (state == S_IDLE) && grant_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = grant_vld && (grant == IDW'(i));
                end
                if (grant_vld) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = S_BUSY;
            end
            S_BUSY: begin
                if (core_done || tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            core_data <= '0;
            core_key  <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
            job_count <= '0;
        end else begin
            if (take) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant == IDW'(i)) begin
                        core_data <= req_data[128*i +: 128];
                        core_key  <= req_key[256*i +: 256];
                    end
                end
                rsp_id <= grant;
                rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
            if (state == S_ISSUE) begin
                tmo_cnt <= '0;
            end
            if (state == S_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                // A done arriving on the watchdog's last cycle still counts as success.
                if (core_done) begin
                    rsp_data <= core_result;
                    rsp_err  <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == S_RESP && rsp_ready) begin
                job_count <= job_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Randomized bench for aes_job_arbiter against a job-level reference model
// (ring-order grant, timeout rule, response count).
module tb_aes_job_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*128-1:0]  req_data;
    logic [NREQ*256-1:0]  req_key;
    logic                 core_start;
    logic [127:0]         core_data;
    logic [255:0]         core_key;
    logic                 core_done;
    logic [127:0]         core_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [127:0]         rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [15:0]          job_count;

    logic [127:0]         d_arr[NREQ];
    logic [255:0]         k_arr[NREQ];
    logic [NREQ-1:0]      pending;

    int n_tests = 0;
    int n_fail  = 0;
    int m_rr    = 0;
    int m_count = 0;

    aes_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .core_start(core_start), .core_data(core_data), .core_key(core_key),
        .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_data[128*i +: 128] = d_arr[i];
        assign req_key[256*i +: 256]  = k_arr[i];
    end
    assign req_valid = pending;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: first pending requester in ring order starting at the model pointer.
    function automatic int model_grant(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Entered and left on a negedge with the DUT idle. done_at is the BUSY cycle
    // index carrying core_done; values past TMO-1 mean the core never answers.
    task automatic run_job(input int done_at, input int bp, input logic [127:0] res,
                           input int rst_at, output int g_obs);
        int              g;
        bit              err;
        int              last;
        logic [NREQ-1:0] oh;
        logic [127:0]    exp_d;
        logic [255:0]    exp_k;
        logic [127:0]    exp_r;
        g  = model_grant(pending);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        #1;
        check("req_ready", req_ready, oh);
        check("busy_idle", busy, 0);
        g_obs = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_obs = i;
        if (g < 0) return;
        exp_d = d_arr[g];
        exp_k = k_arr[g];
        m_rr  = (g + 1) % NREQ;
        @(posedge clk);
        @(negedge clk);
        check("core_start", core_start, 1);
        check("core_data", core_data, exp_d);
        check("core_key", core_key, exp_k);
        check("ready_issue", req_ready, 0);
        check("busy_issue", busy, 1);
        pending[g] = 1'b0;
        d_arr[g]   = rand128();
        k_arr[g]   = {rand128(), rand128()};
        err  = (done_at > TMO - 1);
        last = err ? TMO - 1 : done_at;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                pending = '0;
                rst_n   = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_start", core_start, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_ready", req_ready, 0);
                check("rst_core_data", core_data, 0);
                check("rst_core_key", core_key, 0);
                check("rst_rsp", {rsp_id, rsp_err, rsp_data}, 0);
                check("rst_count", job_count, 0);
                m_rr    = 0;
                m_count = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("busy_wait", rsp_valid, 0);
            check("busy_nostart", core_start, 0);
            core_done   = (i == done_at);
            core_result = res;
        end
        exp_r = err ? 128'd0 : res;
        @(negedge clk);
        core_done = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, g);
        check("rsp_data", rsp_data, exp_r);
        check("rsp_err", rsp_err, err);
        check("data_hold", core_data, exp_d);
        check("key_hold", core_key, exp_k);
        if (err) begin
            core_done   = 1'b1;
            core_result = rand128();
        end
        for (int j = 0; ; j++) begin
            rsp_ready = (j >= bp);
            @(posedge clk);
            if (j >= bp) break;
            @(negedge clk);
            core_done = 1'b0;
            check("bp_valid", rsp_valid, 1);
            check("bp_stable", {rsp_id, rsp_err, rsp_data}, {IDW'(g), err, exp_r});
            check("bp_ready", req_ready, 0);
            check("bp_nostart", core_start, 0);
            check("bp_count", job_count, m_count);
        end
        m_count = (m_count + 1) & 32'hFFFF;
        @(negedge clk);
        rsp_ready = 1'b0;
        core_done = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("job_count", job_count, m_count);
    endtask

    initial begin
        int g;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        pending     = '0;
        core_done   = 1'b0;
        core_result = '0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d_arr[i] = rand128();
            k_arr[i] = {rand128(), rand128()};
        end
        repeat (2) @(negedge clk);
        check("reset_out", {busy, core_start, rsp_valid, req_ready}, 0);
        check("reset_regs", {rsp_id, rsp_err, rsp_data, job_count}, 0);
        check("reset_core", {core_data, core_key}, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_empty", {busy, req_ready}, 0);
        end

        // All four held valid.
        for (int s = 0; s < 5; s++) begin
            pending = '1;
            run_job($urandom_range(0, 10), 0, rand128(), -1, g);
            check("rr_seq", g, rr_exp[s]);
        end
        pending = 4'b0010;
        run_job(2, 0, rand128(), -1, g);
        check("rr_to_2", g, 1);
        pending = 4'b1010;
        run_job(3, 0, rand128(), -1, g);
        check("rr_skip_3", g, 3);
        run_job(3, 0, rand128(), -1, g);
        check("rr_wrap_1", g, 1);

        // Known-answer job on requester 2.
        pending  = 4'b0100;
        d_arr[2] = 128'h00112233445566778899aabbccddeeff;
        k_arr[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_job(56, 0, 128'h8ea2b7ca516745bfeafc49904b496089, -1, g);
        check("kat_grant", g, 2);

        pending = 4'b0001;
        run_job(5, 10, rand128(), -1, g);
        pending = 4'b1000;
        run_job(1000, 2, rand128(), -1, g);
        pending = 4'b0100;
        run_job(TMO - 1, 0, rand128(), -1, g);
        pending = 4'b0010;
        run_job(TMO, 0, rand128(), -1, g);

        for (int n = 0; n < 25; n++) begin
            pending = pending | NREQ'($urandom_range(1, 15));
            run_job($urandom_range(0, TMO + 4), $urandom_range(0, 3), rand128(), -1, g);
        end
        for (int n = 0; n < NREQ && pending != 0; n++) begin
            run_job($urandom_range(0, 20), 0, rand128(), -1, g);
        end

        pending = 4'b0100;
        run_job(1000, 0, rand128(), 5, g);
        pending = 4'b0011;
        run_job(3, 0, rand128(), -1, g);
        check("rst_grant0", g, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
